// File: rtl/alu_seq.sv
// Sequencer that drives an external combinational ALU to execute accumulator
// commands, including an 8-iteration shift-and-add multiply.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_sel,
  output logic [1:0] alu_ls,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_zout,
  output logic [7:0] acc,
  output logic       c_flag,
  output logic       z_flag,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    MUL_ADD = 3'd2,
    MUL_SHF = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_NOR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  localparam logic [1:0] SEL_LS  = 2'b00;
  localparam logic [1:0] SEL_NOR = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SUB = 2'b11;

  localparam logic [1:0] LS_ZERO = 2'b00;
  localparam logic [1:0] LS_SHL  = 2'b01;
  localparam logic [1:0] LS_PASS = 2'b10;
  localparam logic [1:0] LS_SHR  = 2'b11;

  state_e     state, state_nxt;
  op_e        op_r;
  logic [7:0] data_r;
  logic [7:0] m_reg;
  logic [7:0] q_reg;
  logic [2:0] cnt;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = SEL_LS;
    alu_ls    = LS_ZERO;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nxt = (cmd_op == OP_MUL) ? MUL_ADD : EXEC;
      end
      EXEC: begin
        state_nxt = DONE;
        case (op_r)
          OP_LOAD: begin alu_a = data_r; alu_ls = LS_PASS; end
          OP_ADD:  begin alu_a = acc; alu_b = data_r; alu_sel = SEL_ADD; end
          OP_SUB:  begin alu_a = acc; alu_b = data_r; alu_sel = SEL_SUB; end
          OP_NOR:  begin alu_a = acc; alu_b = data_r; alu_sel = SEL_NOR; end
          OP_SHL:  begin alu_a = acc; alu_ls = LS_SHL; end
          OP_SHR:  begin alu_a = acc; alu_ls = LS_SHR; end
          default: ;
        endcase
      end
      MUL_ADD: begin
        alu_a     = acc;
        alu_b     = q_reg[0] ? m_reg : '0;
        alu_sel   = SEL_ADD;
        state_nxt = MUL_SHF;
      end
      MUL_SHF: begin
        alu_a     = m_reg;
        alu_ls    = LS_SHL;
        state_nxt = (cnt == 3'd7) ? DONE : MUL_ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      m_reg  <= '0;
      q_reg  <= '0;
      cnt    <= '0;
      op_r   <= OP_LOAD;
      data_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= op_e'(cmd_op);
            data_r <= cmd_data;
            // Multiplicand is the current accumulator; acc restarts as the product.
            if (cmd_op == OP_MUL) begin
              acc    <= '0;
              m_reg  <= acc;
              q_reg  <= cmd_data;
              cnt    <= '0;
              c_flag <= 1'b0;
            end
          end
        end
        EXEC: begin
          acc    <= alu_result;
          c_flag <= alu_cout;
          z_flag <= alu_zout;
        end
        MUL_ADD: begin
          acc    <= alu_result;
          c_flag <= c_flag | alu_cout;
          z_flag <= alu_zout;
        end
        MUL_SHF: begin
          m_reg <= alu_result;
          q_reg <= q_reg >> 1;
          cnt   <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the external ALU.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_sel, alu_ls;
  logic [7:0] alu_result;
  logic       alu_cout, alu_zout;
  logic [7:0] acc;
  logic       c_flag, z_flag, done;

  int unsigned total = 0;
  int unsigned bad = 0;

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_ls     (alu_ls),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_zout   (alu_zout),
    .acc        (acc),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External ALU: add/sub carry is the 9th bit, shifts and logic give no carry.
  logic [8:0] r9;
  always_comb begin
    r9 = '0;
    case (alu_sel)
      2'b10: r9 = {1'b0, alu_a} + {1'b0, alu_b};
      2'b11: r9 = {1'b0, alu_a} - {1'b0, alu_b};
      2'b01: r9 = {1'b0, ~(alu_a | alu_b)};
      default: begin
        case (alu_ls)
          2'b11:   r9 = {1'b0, alu_a >> 1};
          2'b01:   r9 = {1'b0, alu_a << 1};
          2'b10:   r9 = {1'b0, alu_a};
          default: r9 = '0;
        endcase
      end
    endcase
  end
  assign alu_result = r9[7:0];
  assign alu_cout   = r9[8];
  assign alu_zout   = (r9[7:0] == 8'h00);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, measure edges from acceptance to done, check result.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] d,
                        input int exp_lat, input logic [7:0] e_acc,
                        input logic e_c, input logic e_z);
    int lat;
    int w;
    w = 0;
    while (!cmd_ready && w < 40) begin tick(); w++; end
    chk({tag, "_ready"}, 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 8'($urandom);
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_acc"}, 16'(acc), 16'(e_acc));
    chk({tag, "_c"}, 16'(c_flag), 16'(e_c));
    chk({tag, "_z"}, 16'(z_flag), 16'(e_z));
    chk({tag, "_busy"}, 16'(cmd_ready), 16'd0);
    tick();
    chk({tag, "_done1cyc"}, 16'(done), 16'd0);
    chk({tag, "_rdy_back"}, 16'(cmd_ready), 16'd1);
    chk({tag, "_acc_hold"}, 16'(acc), 16'(e_acc));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_acc", 16'(acc), 16'h00);
    chk("rst_flags", 16'({c_flag, z_flag}), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_alu", 16'({alu_a, alu_sel, alu_ls}), 16'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    do_cmd("load3c", 3'b000, 8'h3C, 1, 8'h3C, 1'b0, 1'b0);
    chk("idle_alu", 16'({alu_a, alu_sel, alu_ls}), 16'd0);
    chk("idle_alub", 16'(alu_b), 16'd0);

    do_cmd("loadf0", 3'b000, 8'hF0, 1, 8'hF0, 1'b0, 1'b0);
    do_cmd("add20", 3'b001, 8'h20, 1, 8'h10, 1'b1, 1'b0);
    do_cmd("sub10", 3'b010, 8'h10, 1, 8'h00, 1'b0, 1'b1);

    do_cmd("load05", 3'b000, 8'h05, 1, 8'h05, 1'b0, 1'b0);
    do_cmd("sub06", 3'b010, 8'h06, 1, 8'hFF, 1'b1, 1'b0);
    do_cmd("nor00", 3'b011, 8'h00, 1, 8'h00, 1'b0, 1'b1);
    do_cmd("load5a", 3'b000, 8'h5A, 1, 8'h5A, 1'b0, 1'b0);
    do_cmd("clr", 3'b110, 8'h77, 1, 8'h00, 1'b0, 1'b1);

    // cmd_valid held across three edges: only the first is accepted.
    do_cmd("load81", 3'b000, 8'h81, 1, 8'h81, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'b100;
    cmd_data  = 8'h00;
    tick();
    chk("hold_busy", 16'(cmd_ready), 16'd0);
    tick();
    chk("hold_done", 16'(done), 16'd1);
    chk("shl_acc", 16'(acc), 16'h02);
    chk("shl_c", 16'(c_flag), 16'd0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_done_off", 16'(done), 16'd0);
    chk("hold_ready", 16'(cmd_ready), 16'd1);
    tick();
    chk("hold_single", 16'(acc), 16'h02);
    chk("hold_nodone", 16'(done), 16'd0);
    do_cmd("shr", 3'b101, 8'h00, 1, 8'h01, 1'b0, 1'b0);

    do_cmd("load0d", 3'b000, 8'h0D, 1, 8'h0D, 1'b0, 1'b0);
    do_cmd("mul0b", 3'b111, 8'h0B, 16, 8'h8F, 1'b0, 1'b0);
    do_cmd("load20", 3'b000, 8'h20, 1, 8'h20, 1'b0, 1'b0);
    do_cmd("mul10", 3'b111, 8'h10, 16, 8'h00, 1'b0, 1'b1);
    do_cmd("loadff", 3'b000, 8'hFF, 1, 8'hFF, 1'b0, 1'b0);
    do_cmd("mulff", 3'b111, 8'hFF, 16, 8'h01, 1'b1, 1'b0);

    // Abort a multiply while in MUL_SHF of iteration 3.
    do_cmd("load0d_b", 3'b000, 8'h0D, 1, 8'h0D, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'b111;
    cmd_data  = 8'h0B;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    chk("mid_shf_drive", 16'({alu_sel, alu_ls}), 16'b0001);
    chk("mid_shf_m", 16'(alu_a), 16'h68);
    rst_n = 1'b0;
    #1;
    chk("abort_acc", 16'(acc), 16'h00);
    chk("abort_flags", 16'({c_flag, z_flag}), 16'd0);
    chk("abort_ready", 16'(cmd_ready), 16'd1);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_alu", 16'({alu_a, alu_sel, alu_ls}), 16'd0);
    tick();
    chk("abort_done2", 16'(done), 16'd0);
    tick();
    rst_n = 1'b1;
    do_cmd("load11", 3'b000, 8'h11, 1, 8'h11, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
